// File: rtl/scr_arbiter.sv
// scr_arbiter: two-master arbiter and access sequencer for the scratch RAM.
// Optional: define SCR_ARB_ROUND_ROBIN_EN for round-robin tie-break.
module scr_arbiter #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              A_REQ,
  input  logic              A_WE,
  input  logic [ADDR_W-1:0] A_ADDR,
  input  logic [DATA_W-1:0] A_WDATA,
  output logic              A_ACK,
  output logic [DATA_W-1:0] A_RDATA,
  input  logic              B_REQ,
  input  logic              B_WE,
  input  logic [ADDR_W-1:0] B_ADDR,
  input  logic [DATA_W-1:0] B_WDATA,
  output logic              B_ACK,
  output logic [DATA_W-1:0] B_RDATA,
  output logic [ADDR_W-1:0] SCR_ADDR,
  output logic              SCR_WE,
  output logic [DATA_W-1:0] SCR_DATA_IN,
  input  logic [DATA_W-1:0] SCR_DATA_OUT,
  output logic              BUSY
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic              win_b_q, win_b_d;
  logic              pick_b;
  logic              grant;
  logic [ADDR_W-1:0] addr_d;
  logic              we_d;
  logic [DATA_W-1:0] din_d;
  logic              a_ack_d, b_ack_d;
  logic [DATA_W-1:0] a_rd_d, b_rd_d;
  logic              busy_d;

  assign grant = (state_q == IDLE) & (A_REQ | B_REQ);

`ifdef SCR_ARB_ROUND_ROBIN_EN
  logic last_b_q, last_b_d;

  // Tie goes to the port that lost the previous grant
  always_comb begin
    pick_b = 1'b0;
    unique case (1'b1)
      A_REQ & B_REQ:  pick_b = ~last_b_q;
      ~A_REQ & B_REQ: pick_b = 1'b1;
      default:        pick_b = 1'b0;
    endcase
  end

  // Remember the winner of every grant
  always_comb begin
    last_b_d = last_b_q;
    if (grant) last_b_d = pick_b;
  end

  // Last-winner register; reset to B so A takes the first tie
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) last_b_q <= 1'b1;
    else        last_b_q <= last_b_d;
  end
`else
  // Fixed priority: A always wins a tie
  always_comb begin
    pick_b = 1'b0;
    unique case (1'b1)
      ~A_REQ & B_REQ: pick_b = 1'b1;
      default:        pick_b = 1'b0;
    endcase
  end
`endif

  // Next state and next values of all registered outputs
  always_comb begin
    state_d = state_q;
    win_b_d = win_b_q;
    addr_d  = SCR_ADDR;
    we_d    = SCR_WE;
    din_d   = SCR_DATA_IN;
    a_ack_d = 1'b0;
    b_ack_d = 1'b0;
    a_rd_d  = A_RDATA;
    b_rd_d  = B_RDATA;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = ACCESS;
          win_b_d = pick_b;
          addr_d  = pick_b ? B_ADDR  : A_ADDR;
          we_d    = pick_b ? B_WE    : A_WE;
          din_d   = pick_b ? B_WDATA : A_WDATA;
        end
      end
      ACCESS: begin
        state_d = DONE;
        we_d    = 1'b0;
        a_ack_d = ~win_b_q;
        b_ack_d = win_b_q;
        if (!SCR_WE) begin
          if (win_b_q) b_rd_d = SCR_DATA_OUT;
          else         a_rd_d = SCR_DATA_OUT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and winner registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      win_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      win_b_q <= win_b_d;
    end
  end

  // Registered outputs; reset drops the RAM write enable at once
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      SCR_ADDR    <= '0;
      SCR_WE      <= 1'b0;
      SCR_DATA_IN <= '0;
      A_ACK       <= 1'b0;
      B_ACK       <= 1'b0;
      A_RDATA     <= '0;
      B_RDATA     <= '0;
      BUSY        <= 1'b0;
    end else begin
      SCR_ADDR    <= addr_d;
      SCR_WE      <= we_d;
      SCR_DATA_IN <= din_d;
      A_ACK       <= a_ack_d;
      B_ACK       <= b_ack_d;
      A_RDATA     <= a_rd_d;
      B_RDATA     <= b_rd_d;
      BUSY        <= busy_d;
    end
  end

endmodule
